// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite pixel pipeline: sprite geometry,
// transparent palette index and the 8-entry RGB palette.
package sprite_pkg;

  localparam int SPR_W_DEF  = 55;
  localparam int SPR_H_DEF  = 41;
  localparam int ADDR_W_DEF = 12;

  localparam logic [2:0] TRANSP_IDX = 3'd7;

  typedef logic [23:0] rgb_t;

  localparam rgb_t PALETTE [8] = '{
    24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000,
    24'hF8D800, 24'hC07000, 24'h000000, 24'h000000
  };

  function automatic rgb_t palette_lookup(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational sprite hit test and ROM address generation for one pixel,
// relative to the frame-latched sprite position and mirror flag.
module sprite_hit_calc
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              pix_valid,
  input  logic              vis,
  input  logic              flip,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  logic [10:0] col;
  logic [10:0] row;
  logic [10:0] colx;
  logic        col_in;
  logic        row_in;

  always_comb begin
    // Offsets are taken from the pixel, so a sprite hanging off the right or
    // bottom edge is clipped rather than wrapped to the opposite side.
    col    = {1'b0, draw_x} - {1'b0, pos_x};
    row    = {1'b0, draw_y} - {1'b0, pos_y};
    col_in = !col[10] && (col < 11'(SPR_W));
    row_in = !row[10] && (row < 11'(SPR_H));
    hit    = pix_valid && vis && col_in && row_in;
    colx   = flip ? (11'(SPR_W - 1) - col) : col;
    addr   = ADDR_W'(ADDR_W'(row) * ADDR_W'(SPR_W)) + ADDR_W'(colx);
  end

endmodule

// File: rtl/sprite_draw.sv
// Sprite pixel stage: frame-latched position, hit/address calc, ROM address
// register, hit pipeline and registered transparency + palette output.
module sprite_draw
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              visible,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic              sprite_on,
  output logic [23:0]       rgb
);

  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic              flip_q, flip_d;
  logic              vis_q, vis_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_d1_q, hit_d1_d;
  logic              hit_d2_q, hit_d2_d;
  logic              sprite_on_q, sprite_on_d;
  rgb_t              rgb_q, rgb_d;

  logic              hit;
  logic [ADDR_W-1:0] addr;

  sprite_hit_calc #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ADDR_W (ADDR_W)
  ) u_hit_calc (
    .pix_valid (pix_valid),
    .vis       (vis_q),
    .flip      (flip_q),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .pos_x     (pos_x_q),
    .pos_y     (pos_y_q),
    .hit       (hit),
    .addr      (addr)
  );

  always_comb begin
    pos_x_d     = frame_start ? pos_x   : pos_x_q;
    pos_y_d     = frame_start ? pos_y   : pos_y_q;
    flip_d      = frame_start ? flip_h  : flip_q;
    vis_d       = frame_start ? visible : vis_q;
    // Hold the address outside the sprite so the ROM bus stays quiet.
    rom_addr_d  = hit ? addr : rom_addr_q;
    hit_d1_d    = hit;
    hit_d2_d    = hit_d1_q;
    sprite_on_d = hit_d2_q && (rom_data != TRANSP_IDX);
    rgb_d       = sprite_on_d ? palette_lookup(rom_data) : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      flip_q      <= 1'b0;
      vis_q       <= 1'b0;
      rom_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      sprite_on_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      flip_q      <= flip_d;
      vis_q       <= vis_d;
      rom_addr_q  <= rom_addr_d;
      hit_d1_q    <= hit_d1_d;
      hit_d2_q    <= hit_d2_d;
      sprite_on_q <= sprite_on_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign sprite_on = sprite_on_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_sprite_draw.sv
// Randomised bench for sprite_draw with a registered-read ROM model and a
// pixel-level reference model that predicts output three cycles later.
module tb_sprite_draw;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        flip_h, visible;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic        sprite_on;
  logic [23:0] rgb;

  always #5 Clk = ~Clk;

  sprite_draw dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_h      (flip_h),
    .visible     (visible),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sprite_on   (sprite_on),
    .rgb         (rgb)
  );

  logic [2:0] rom [0:4095];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic        on;
    logic [23:0] rgb;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   m_px, m_py, m_addr;
  bit   m_flip, m_vis;
  exp_t expq[$];

  function automatic logic [23:0] pal(input int idx);
    case (idx)
      1:       return 24'hFFFFFF;
      4:       return 24'hF8D800;
      5:       return 24'hC07000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_flip = 0; m_vis = 0; m_addr = 0;
    expq.delete();
  endtask

  // Present one pixel for one clock; returns the expectation that falls due now.
  task automatic cycle(input int x, input int y, input bit v, input bit fs,
                       output bit have, output exp_t e, output int e_addr);
    int   col, row, a;
    exp_t n;
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = v; frame_start = fs;
    col = x - m_px;
    row = y - m_py;
    n = '0;
    if (v && m_vis && col >= 0 && col < 55 && row >= 0 && row < 41) begin
      a = row * 55 + (m_flip ? 54 - col : col);
      m_addr = a;
      if (rom[a] != 3'd7) begin
        n.on = 1'b1;
        n.rgb = pal(int'(rom[a]));
      end
    end
    expq.push_back(n);
    if (fs) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_flip = flip_h; m_vis = visible;
    end
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    e_addr = m_addr;
    have = 1'b0;
    e = '0;
    if (expq.size() == 3) begin
      e = expq.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic set_frame(input int px, input int py, input bit fl, input bit vi);
    pos_x = 10'(px); pos_y = 10'(py); flip_h = fl; visible = vi;
  endtask

  task automatic test_reset();
    bit have; exp_t e; int ea; int x, y;
    checks++;
    if (sprite_on !== 1'b0 || rgb !== 24'h0 || rom_addr !== 12'h0) begin
      errors++;
      $display("FAIL reset_state on=%0b rgb=%h addr=%0d want 0/0/0", sprite_on, rgb, rom_addr);
    end
    set_frame(0, 0, 0, 1);
    for (int i = 0; i < 1700; i++) begin
      if (i < 640) begin x = i; y = 0; end
      else if (i < 1120) begin x = 0; y = i - 640; end
      else begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
      cycle(x, y, 1, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb || sprite_on !== 1'b0 || rgb !== 24'h0) begin
          errors++;
          $display("FAIL reset_sweep on=%0b rgb=%h want on=0 rgb=0", sprite_on, rgb);
        end
      end
    end
    $display("test_reset: swept pixels with no frame_start");
  endtask

  task automatic test_position();
    bit have; exp_t e; int ea;
    set_frame(100, 50, 0, 1);
    cycle(0, 0, 0, 1, have, e, ea);
    cycle(100, 50, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd0 || rom_addr !== 12'(ea)) begin
      errors++; $display("FAIL pos_origin rom_addr=%0d want 0", rom_addr);
    end
    cycle(154, 90, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd2254) begin
      errors++; $display("FAIL pos_last rom_addr=%0d want 2254", rom_addr);
    end
    cycle(155, 50, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd2254) begin
      errors++; $display("FAIL pos_outside_hold rom_addr=%0d want 2254", rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb) begin
          errors++; $display("FAIL pos_out on=%0b rgb=%h want on=%0b rgb=%h", sprite_on, rgb, e.on, e.rgb);
        end
      end
    end
    $display("test_position: origin, last pixel and right-edge miss");
  endtask

  task automatic test_flip();
    bit have; exp_t e; int ea;
    set_frame(100, 50, 1, 1);
    cycle(0, 0, 0, 1, have, e, ea);
    cycle(100, 51, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd109) begin
      errors++; $display("FAIL flip_left rom_addr=%0d want 109", rom_addr);
    end
    cycle(154, 51, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd55) begin
      errors++; $display("FAIL flip_right rom_addr=%0d want 55", rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb) begin
          errors++; $display("FAIL flip_out on=%0b rgb=%h want on=%0b rgb=%h", sprite_on, rgb, e.on, e.rgb);
        end
      end
    end
    $display("test_flip: mirrored addresses on row 1");
  endtask

  task automatic test_rom_burst();
    bit have; exp_t e; int ea;
    set_frame(100, 50, 0, 1);
    cycle(0, 0, 0, 1, have, e, ea);
    for (int i = 0; i < 12; i++) begin
      if (i < 10) cycle(100 + i, 50, 1, 0, have, e, ea);
      else        cycle(0, 0, 0, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb) begin
          errors++; $display("FAIL burst_px%0d on=%0b rgb=%h want on=%0b rgb=%h", i - 2, sprite_on, rgb, e.on, e.rgb);
        end
      end
      if (i == 2) begin
        checks++;
        if (sprite_on !== 1'b0 || rgb !== 24'h0) begin
          errors++; $display("FAIL burst_transparent on=%0b rgb=%h want on=0 rgb=0", sprite_on, rgb);
        end
      end
      if (i == 4) begin
        checks++;
        if (sprite_on !== 1'b1 || rgb !== 24'hF8D800) begin
          errors++; $display("FAIL burst_yellow on=%0b rgb=%h want on=1 rgb=f8d800", sprite_on, rgb);
        end
      end
    end
    $display("test_rom_burst: 10-pixel burst with 3-cycle latency");
  endtask

  task automatic test_clip();
    bit have; exp_t e; int ea;
    set_frame(620, 470, 0, 1);
    cycle(0, 0, 0, 1, have, e, ea);
    cycle(639, 479, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd514) begin
      errors++; $display("FAIL clip_corner rom_addr=%0d want 514", rom_addr);
    end
    for (int i = 0; i < 300; i++) begin
      if (i < 100) cycle($urandom_range(0, 40), $urandom_range(0, 30), 1, 0, have, e, ea);
      else if (i < 297) cycle($urandom_range(600, 639), $urandom_range(460, 479), 1, 0, have, e, ea);
      else cycle(0, 0, 0, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb || rom_addr !== 12'(ea)) begin
          errors++;
          $display("FAIL clip_px on=%0b rgb=%h addr=%0d want on=%0b rgb=%h addr=%0d",
                   sprite_on, rgb, rom_addr, e.on, e.rgb, ea);
        end
        if (i > 2 && i < 102 && sprite_on !== 1'b0) begin
          errors++; $display("FAIL clip_nowrap on=%0b want on=0", sprite_on);
        end
      end
    end
    $display("test_clip: bottom-right clipping, no wrap to origin");
  endtask

  task automatic test_latch();
    bit have; exp_t e; int ea;
    set_frame(200, 100, 0, 1);
    cycle(0, 0, 0, 1, have, e, ea);
    pos_x = 10'd300;
    for (int i = 0; i < 10; i++) begin
      cycle(200 + (i % 5), 100 + i / 5, 1, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb || rom_addr !== 12'(ea)) begin
          errors++; $display("FAIL latch_hold on=%0b rgb=%h addr=%0d want on=%0b rgb=%h addr=%0d",
                             sprite_on, rgb, rom_addr, e.on, e.rgb, ea);
        end
      end
    end
    checks++;
    if (rom_addr !== 12'd59) begin
      errors++; $display("FAIL latch_no_update rom_addr=%0d want 59", rom_addr);
    end
    cycle(201, 100, 1, 1, have, e, ea);
    checks++;
    if (rom_addr !== 12'd1) begin
      errors++; $display("FAIL latch_old_pos rom_addr=%0d want 1", rom_addr);
    end
    cycle(301, 101, 1, 0, have, e, ea);
    checks++;
    if (rom_addr !== 12'd56) begin
      errors++; $display("FAIL latch_new_pos rom_addr=%0d want 56", rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb) begin
          errors++; $display("FAIL latch_out on=%0b rgb=%h want on=%0b rgb=%h", sprite_on, rgb, e.on, e.rgb);
        end
      end
    end
    $display("test_latch: position only moves on frame_start");
  endtask

  task automatic test_random();
    bit have; exp_t e; int ea; int x, y; bit fs;
    for (int f = 0; f < 25; f++) begin
      set_frame($urandom_range(0, 650), $urandom_range(0, 490), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0);
      cycle(0, 0, 0, 1, have, e, ea);
      for (int k = 0; k < 120; k++) begin
        x = int'(pos_x) + int'($urandom_range(0, 70)) - 8;
        y = int'(pos_y) + int'($urandom_range(0, 56)) - 8;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        fs = 1'b0;
        if (k == 60 && $urandom_range(0, 1) == 1) begin
          pos_x = 10'(int'(pos_x) + int'($urandom_range(0, 20)));
          flip_h = ~flip_h;
          fs = 1'b1;
        end
        cycle(x, y, $urandom_range(0, 4) != 0, fs, have, e, ea);
        if (have) begin
          checks++;
          if (sprite_on !== e.on || rgb !== e.rgb || rom_addr !== 12'(ea)) begin
            errors++;
            $display("FAIL random f%0d k%0d on=%0b rgb=%h addr=%0d want on=%0b rgb=%h addr=%0d",
                     f, k, sprite_on, rgb, rom_addr, e.on, e.rgb, ea);
          end
        end
      end
    end
    $display("test_random: 25 random frames");
  endtask

  task automatic test_reset_mid();
    bit have; exp_t e; int ea;
    for (int i = 0; i < 10; i++) rom[55 + i] = 3'd5;
    set_frame(100, 50, 0, 1);
    cycle(0, 0, 0, 1, have, e, ea);
    for (int i = 0; i < 6; i++) begin
      cycle(100 + i, 51, 1, 0, have, e, ea);
      if (have) begin
        checks++;
        if (sprite_on !== e.on || rgb !== e.rgb) begin
          errors++; $display("FAIL midrst_pre on=%0b rgb=%h want on=%0b rgb=%h", sprite_on, rgb, e.on, e.rgb);
        end
      end
    end
    DrawX = 10'd106; DrawY = 10'd51; pix_valid = 1'b1;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (sprite_on !== 1'b0 || rgb !== 24'h0 || rom_addr !== 12'h0) begin
      errors++; $display("FAIL midrst_immediate on=%0b rgb=%h addr=%0d want 0/0/0", sprite_on, rgb, rom_addr);
    end
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    pix_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(100 + (i % 10), 51, 1, 0, have, e, ea);
      checks++;
      if (sprite_on !== 1'b0 || rgb !== 24'h0 || rom_addr !== 12'(ea)) begin
        errors++; $display("FAIL midrst_after on=%0b rgb=%h addr=%0d want on=0 rgb=0 addr=%0d",
                           sprite_on, rgb, rom_addr, ea);
      end
    end
    $display("test_reset_mid: reset mid-burst flushes pipeline");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 3'($urandom_range(0, 7));
    rom[0] = 3'd7; rom[1] = 3'd1; rom[2] = 3'd4; rom[3] = 3'd5;
    Reset_n = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0;
    set_frame(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    test_reset();
    test_position();
    test_flip();
    test_rom_burst();
    test_clip();
    test_latch();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_draw.md
# sprite_draw

Pixel-pipeline stage directly downstream of the sprite ROM. For each pixel coordinate from the VGA controller it decides whether the pixel falls inside the 55×41 sprite, forms the ROM address and drives it to the ROM. It then takes the 3-bit palette index the ROM returns, applies transparency and the palette, and emits a registered 24-bit RGB value with a sprite-hit flag to the colour mapper. Sprite position, flip and visibility are latched once per frame so the sprite never tears mid-frame.

## Interface
- SPR_W, 55, sprite width in pixels
- SPR_H, 41, sprite height in pixels
- ADDR_W, 12, ROM address width (SPR_W*SPR_H = 2255 ≤ 4096)
- TRANSP_IDX, 7, palette index treated as transparent
- Clk  in  1  system/pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  DrawX/DrawY valid this cycle (active video)
- DrawX  in  10  current pixel column, 0–639
- DrawY  in  10  current pixel row, 0–479
- pos_x  in  10  requested sprite left edge
- pos_y  in  10  requested sprite top edge
- flip_h  in  1  requested horizontal mirror
- visible  in  1  requested sprite enable
- rom_addr  out  ADDR_W  address to sprite ROM (ROM registers it; data valid one cycle later)
- rom_data  in  3  palette index from ROM
- sprite_on  out  1  opaque sprite pixel at the output stage
- rgb  out  24  {R,G,B} of the sprite pixel; 0 when sprite_on=0

## Operation
- Frame latch: on a cycle with frame_start=1, register pos_x, pos_y, flip_h and visible into pos_x_q, pos_y_q, flip_q and vis_q. These values are used for every pixel from the next cycle on. A pixel presented in the same cycle as frame_start uses the old latched values.
- Stage 0 (combinational into stage-1 registers):
  - col = DrawX − pos_x_q and row = DrawY − pos_y_q, computed as 11-bit signed.
  - hit = pix_valid & vis_q & 0≤col<SPR_W & 0≤row<SPR_H.
  - colx = flip_q ? SPR_W−1−col : col.
  - addr = row*SPR_W + colx, truncated to ADDR_W. The multiply is by a constant.
- Stage 1: register rom_addr and hit_d1. When hit=0, rom_addr holds its previous value, so there is no toggling outside the sprite.
- Stage 2: the ROM returns rom_data. Pipe hit_d1 to hit_d2.
- Stage 3: sprite_on = hit_d2 & (rom_data ≠ TRANSP_IDX). rgb = sprite_on ? PALETTE[rom_data] : 0. Both are registered.
- Off-screen clipping: a sprite partly beyond x=639 or y=479 is simply clipped. There is no wrap-around, because col and row are measured from the pixel, not from the sprite.
- Reset: pos_x_q=0, pos_y_q=0, flip_q=0, vis_q=0, rom_addr=0, all hit pipeline bits 0, sprite_on=0, rgb=0. The sprite stays invisible until the first frame_start.
- Reset asserted mid-frame clears the pipeline immediately. No stale pixel emerges after Reset_n is released.

## Timing
- Latency: DrawX/DrawY presented at cycle N → rgb/sprite_on valid at N+3. The colour mapper delays its coordinates by 3 to match.
- Throughput: one pixel per cycle, with no stalls and no backpressure.
- rom_addr changes at N+1. The ROM output is sampled at N+3, into the output register.
- frame_start at cycle F: latched values take effect for pixels presented at F+1 and later.
- pix_valid=0 at cycle N forces sprite_on=0 at N+3, whatever the coordinates.

## Structure
- Shared package sprite_pkg holds:
  - SPR_W and SPR_H defaults.
  - TRANSP_IDX.
  - typedef rgb_t (logic [23:0]).
  - PALETTE constant, 8 entries: 0=24'h000000, 1=24'hFFFFFF, 4=24'hF8D800, 5=24'hC07000, all others 24'h000000.
- One sub-module: sprite_hit_calc. It takes coordinates, latched position and flip, and produces hit and addr. It is purely combinational.
- The ROM is instantiated beside this block at top level, not inside it.

## Test plan
- After reset with no frame_start, sweep the full frame → sprite_on=0 and rgb=0 everywhere, including DrawX=0, DrawY=0.
- pos=(100,50), visible=1, flip=0, frame_start pulse; present (100,50) → rom_addr=0 at N+1. Present (154,90) → rom_addr=2254. Present (155,50) → hit=0.
- Same position with flip_h=1: present (100,51) → rom_addr=55+54=109. Present (154,51) → rom_addr=55.
- ROM model returning 7 at address 0 and 4 at address 2: sprite_on=0/rgb=0 at N+3 for the first, sprite_on=1/rgb=24'hF8D800 for the second. A 10-pixel burst emerges with exactly 3-cycle latency.
- pos=(620,470): pixels (639,479) hit with addr=9*55+19=514. No hit anywhere near x=0 or y=0 (no wrap).
- Change pos_x mid-frame without frame_start → output unchanged. Pulse frame_start in the same cycle as a hit pixel → that pixel uses the old position, the next uses the new. Assert Reset_n low mid-burst → sprite_on=0 immediately and nothing emerges after release.
